spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
Command sequencer between the SPI slave's 10-bit receive word and a single-port byte RAM. It decodes rx_data[9:8] as an opcode: write-address, write-data, read-address or read-data. It issues the RAM write or read strobes, then returns read bytes on tx_data/tx_valid for the slave to shift out on MISO. It also enforces the read-address-before-read-data ordering.

Parameters:
MEM_DEPTH, 256, RAM words; 2..256
ADDR_SIZE, 8, RAM address width = clog2(MEM_DEPTH); the low ADDR_SIZE bits of the 8-bit payload are used
RD_LATENCY, 1, RAM clocks from read strobe edge to valid mem_rdata; 1..3
AUTO_INC, 0, 1 = post-increment wr_addr/rd_addr after each data access, wrapping MEM_DEPTH-1 -> 0

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  10  command word from SPI slave: [9:8] opcode, [7:0] payload
rx_valid  in  1  level from SPI slave; may stay high many cycles per word
ss_n  in  1  SPI slave select; high = transaction ended
tx_data  out  8  read byte to SPI slave
tx_valid  out  1  tx_data valid; held until released
mem_en  out  1  RAM access strobe, one cycle per access
mem_we  out  1  1 = write, 0 = read (qualified by mem_en)
mem_addr  out  ADDR_SIZE  RAM address
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data
busy  out  1  high in READ_ISSUE/READ_WAIT
seq_err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset (async): state IDLE; all outputs 0; wr_addr=rd_addr=0; rd_armed=0; rx_valid_q=0. Reset mid-read aborts it with no tx_valid.
- Accept = rx_valid & ~rx_valid_q, where rx_valid_q is the registered rx_valid. A held-high rx_valid yields exactly one accept. rx_data is sampled on the accept cycle.
- All outputs are registered. Accept at edge N -> effects visible after edge N.
- Opcode 00: wr_addr <= payload. No RAM access. Stay in or return to IDLE.
- Opcode 01: for one cycle after edge N: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=payload (state WRITE_CYC). Then IDLE. If AUTO_INC, wr_addr+1 modulo MEM_DEPTH.
- Opcode 10: rd_addr <= payload; rd_armed <= 1. No RAM access.
- Opcode 11 with rd_armed=1:
  - READ_ISSUE: mem_en=1, mem_we=0, mem_addr=rd_addr for one cycle.
  - READ_WAIT: wait RD_LATENCY cycles, then capture mem_rdata into tx_data and set tx_valid=1 (state TX_HOLD).
  - Net effect: tx_valid rises on edge N+1+RD_LATENCY.
  - rd_armed cleared unless AUTO_INC=1. If AUTO_INC, rd_addr+1 modulo MEM_DEPTH.
- Opcode 11 with rd_armed=0: seq_err pulse; no RAM access; tx_valid stays 0; tx_data unchanged.
- Accept while busy: command dropped, seq_err pulse, in-flight read completes normally.
- TX_HOLD: tx_valid and tx_data held stable. Exit to IDLE with tx_valid=0 on either:
  - ss_n=1, or
  - a new accept; the command is then decoded as from IDLE.
  - Both in the same cycle: the accept wins and is processed.
- ss_n=1 in other states: no effect. Strobes are never cut short.
- mem_en is never asserted outside WRITE_CYC/READ_ISSUE. mem_we=0 whenever mem_en=0.
- The payload is truncated to ADDR_SIZE bits when MEM_DEPTH<256.
- States: IDLE, WRITE_CYC, READ_ISSUE, READ_WAIT, TX_HOLD. Encoding is free, one-hot allowed.
- Implementation budget: 150-250 lines.

Decomposition:
- Shared package spi_ram_pkg: opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11; state enum; field bit positions of the command word.
- Sub-module: none; a small edge detector stays inline.
- The RAM itself stays a separate existing block; the bench uses a behavioural RAM model honoring RD_LATENCY.

Test Plan:
- Write path: accept 10'h0_3C then 10'h1_A5 -> one cycle of mem_en=1, mem_we=1, mem_addr=3C, mem_wdata=A5; no other strobes.
- Read path (RD_LATENCY=2): after the write above, accept 10'h2_3C then 10'h3_00 at edge N -> read strobe addr=3C after edge N; tx_valid=1, tx_data=A5 on edge N+3; held until ss_n=1, then tx_valid=0.
- Ordering error: from reset, accept 10'h3_00 -> seq_err one cycle; mem_en stays 0; tx_valid stays 0. A second 10'h3_00 after a completed read also gives seq_err (AUTO_INC=0).
- Held rx_valid: keep rx_valid high 20 cycles with 10'h1_55 -> exactly one write strobe.
- AUTO_INC=1, MEM_DEPTH=256: wr_addr=FF, two write-data commands (11, 22) -> writes at FF then 00. Reset asserted during READ_WAIT -> all outputs 0 immediately; no tx_valid afterwards.
- TX_HOLD contention: with tx_valid=1, raise ss_n and accept 10'h0_10 in the same cycle -> tx_valid=0 next cycle, wr_addr=10.

Source files
------------

// File: rtl/spi_ram_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, command word
// field positions and FSM state codes.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int CMD_OP_HI = 9;
  localparam int CMD_OP_LO = 8;
  localparam int CMD_PL_HI = 7;
  localparam int CMD_PL_LO = 0;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WRITE_CYC  = 3'd1;
  localparam logic [2:0] ST_READ_ISSUE = 3'd2;
  localparam logic [2:0] ST_READ_WAIT  = 3'd3;
  localparam logic [2:0] ST_TX_HOLD    = 3'd4;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI command words into byte-RAM write/read strobes and
// returns read bytes to the SPI slave; enforces read-address before read-data.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 1,
  parameter int AUTO_INC   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 ss_n,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 seq_err
);

  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  logic [2:0]           state_q, state_d;
  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 rd_armed_q, rd_armed_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d, seq_err_q, seq_err_d;

  logic                 accept, decode;
  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] pl_addr;

  // A level-held rx_valid counts as one command: only its rising edge accepts.
  assign accept  = rx_valid & ~rx_valid_q;
  assign opcode  = rx_data[CMD_OP_HI:CMD_OP_LO];
  assign payload = rx_data[CMD_PL_HI:CMD_PL_LO];
  assign pl_addr = rx_data[CMD_PL_LO +: ADDR_SIZE];

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_armed_d  = rd_armed_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    seq_err_d   = 1'b0;
    decode      = 1'b0;

    case (state_q)
      ST_IDLE, ST_WRITE_CYC: begin
        state_d = ST_IDLE;
        decode  = accept;
      end
      ST_READ_ISSUE: begin
        state_d   = ST_READ_WAIT;
        cnt_d     = '0;
        seq_err_d = accept;
      end
      ST_READ_WAIT: begin
        seq_err_d = accept;
        if (cnt_q == 2'(RD_LATENCY - 1)) begin
          tx_data_d  = mem_rdata;
          tx_valid_d = 1'b1;
          state_d    = ST_TX_HOLD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_TX_HOLD: begin
        // A new accept takes priority over ss_n and is decoded as from IDLE.
        if (accept || ss_n) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
          decode     = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (decode) begin
      case (opcode)
        OP_WR_ADDR: wr_addr_d = pl_addr;
        OP_WR_DATA: begin
          state_d     = ST_WRITE_CYC;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = payload;
          if (AUTO_INC != 0) wr_addr_d = addr_inc(wr_addr_q);
        end
        OP_RD_ADDR: begin
          rd_addr_d  = pl_addr;
          rd_armed_d = 1'b1;
        end
        default: begin
          if (rd_armed_q) begin
            state_d    = ST_READ_ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr_q;
            if (AUTO_INC != 0) rd_addr_d  = addr_inc(rd_addr_q);
            else               rd_armed_d = 1'b0;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      endcase
    end

    busy_d = (state_d == ST_READ_ISSUE) || (state_d == ST_READ_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_armed_q  <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_armed_q  <= rd_armed_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (latency 2 / no auto-inc, latency 1 /
// auto-inc) share stimulus; a transaction-level model predicts every cycle.
module tb_spi_ram_ctrl;

  localparam int L0 = 2;
  localparam int L1 = 1;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       txv;
    logic [7:0] txd;
    logic       err;
    logic       busy;
  } outs_t;

  typedef struct packed {
    logic       rv;
    logic [9:0] d;
    logic       ss;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic       ss_n = 1'b0;
  logic [9:0] rx_data = 10'h0;
  logic       ram_clr;

  logic       en [2], we [2], txv [2], err [2], bsy [2];
  logic [7:0] addr [2], wd [2], txd [2], rdata [2];
  outs_t      act [2];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(L0), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
    .tx_data(txd[0]), .tx_valid(txv[0]), .mem_en(en[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wd[0]), .mem_rdata(rdata[0]),
    .busy(bsy[0]), .seq_err(err[0]));

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(L1), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
    .tx_data(txd[1]), .tx_valid(txv[1]), .mem_en(en[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wd[1]), .mem_rdata(rdata[1]),
    .busy(bsy[1]), .seq_err(err[1]));

  assign act[0] = {en[0], we[0], addr[0], wd[0], txv[0], txd[0], err[0], bsy[0]};
  assign act[1] = {en[1], we[1], addr[1], wd[1], txv[1], txd[1], err[1], bsy[1]};

  // Behavioural RAMs: read data appears RD_LATENCY clocks after the strobe edge.
  logic [7:0] ram [2][256];
  logic [7:0] rpipe [2][3];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_clr) for (int a = 0; a < 256; a++) ram[i][a] <= 8'h00;
      else if (en[i] && we[i]) ram[i][addr[i]] <= wd[i];
      if (en[i] && !we[i]) rpipe[i][0] <= ram[i][addr[i]];
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end
  assign rdata[0] = rpipe[0][L0-1];
  assign rdata[1] = rpipe[1][L1-1];

  // Reference model state
  logic [7:0] m_wr [2], m_rd [2], m_pend [2], m_txd [2];
  logic       m_arm [2], m_rxq [2], m_txv [2];
  int         m_rc [2];
  logic [7:0] m_mem [2][256];
  outs_t      exp_o [2];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         nw0, nw1;
  vec_t       tbl [$];

  function automatic string fmt(input outs_t o);
    return $sformatf("en=%b we=%b addr=%h wd=%h txv=%b txd=%h err=%b busy=%b",
                     o.en, o.we, o.addr, o.wd, o.txv, o.txd, o.err, o.busy);
  endfunction

  task automatic chk(input string nm, input outs_t a, input outs_t x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got {%s} expected {%s}", nm, cyc, fmt(a), fmt(x));
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, a, x);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 8'h00; m_rd[i] = 8'h00; m_pend[i] = 8'h00; m_txd[i] = 8'h00;
      m_arm[i] = 1'b0; m_rxq[i] = 1'b0; m_txv[i] = 1'b0; m_rc[i] = 0;
      exp_o[i] = '0;
    end
  endtask

  // One clock edge of the command rules for instance i.
  task automatic model_edge(input int i, input int lat, input bit ai);
    logic acc;
    logic [7:0] pl;
    outs_t e;
    acc = rx_valid && !m_rxq[i];
    m_rxq[i] = rx_valid;
    pl = rx_data[7:0];
    e = '0;
    if (m_rc[i] > 0) begin
      m_rc[i]--;
      e.err = acc;
      if (m_rc[i] == 0) begin
        m_txv[i] = 1'b1;
        m_txd[i] = m_pend[i];
      end
    end else begin
      if (m_txv[i] && (acc || ss_n)) m_txv[i] = 1'b0;
      if (acc) begin
        case (rx_data[9:8])
          2'b00: m_wr[i] = pl;
          2'b01: begin
            e.en = 1'b1; e.we = 1'b1; e.addr = m_wr[i]; e.wd = pl;
            m_mem[i][m_wr[i]] = pl;
            if (ai) m_wr[i] = m_wr[i] + 8'd1;
          end
          2'b10: begin m_rd[i] = pl; m_arm[i] = 1'b1; end
          default: begin
            if (m_arm[i]) begin
              e.en = 1'b1; e.addr = m_rd[i];
              m_pend[i] = m_mem[i][m_rd[i]];
              m_rc[i] = 1 + lat;
              if (ai) m_rd[i] = m_rd[i] + 8'd1;
              else    m_arm[i] = 1'b0;
            end else begin
              e.err = 1'b1;
            end
          end
        endcase
      end
    end
    e.txv = m_txv[i];
    e.txd = m_txd[i];
    e.busy = (m_rc[i] > 0);
    exp_o[i] = e;
  endtask

  task automatic step(input logic rv, input logic [9:0] d, input logic s);
    rx_valid = rv; rx_data = d; ss_n = s;
    @(posedge clk);
    model_edge(0, L0, 1'b0);
    model_edge(1, L1, 1'b1);
    cyc++;
    @(negedge clk);
    chk("dut0 vs model", act[0], exp_o[0]);
    chk("dut1 vs model", act[1], exp_o[1]);
  endtask

  function automatic vec_t mk(input logic rv, input logic [9:0] d, input logic ss,
                              input logic e, input logic w, input logic [7:0] a,
                              input logic [7:0] wdat, input logic tv, input logic [7:0] td,
                              input logic er, input logic b);
    vec_t v;
    v.rv = rv; v.d = d; v.ss = ss;
    v.exp = {e, w, a, wdat, tv, td, er, b};
    return v;
  endfunction

  initial begin
    // Expected outputs of the latency-2, no-auto-inc instance after each edge.
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h03C, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(0, 10'h03C, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h1A5, 0, 1,1,8'h3C,8'hA5, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h1A5, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h300, 0, 0,0,8'h00,8'h00, 0,8'h00, 1,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h23C, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,0));
    tbl.push_back(mk(1, 10'h300, 0, 1,0,8'h3C,8'h00, 0,8'h00, 0,1));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'h00, 0,1));
    tbl.push_back(mk(1, 10'h077, 0, 0,0,8'h00,8'h00, 0,8'h00, 1,1));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 1,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 1,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 1, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(1, 10'h300, 0, 0,0,8'h00,8'h00, 0,8'hA5, 1,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(1, 10'h23C, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(1, 10'h300, 0, 1,0,8'h3C,8'h00, 0,8'hA5, 0,1));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,1));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,1));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 1,8'hA5, 0,0));
    tbl.push_back(mk(1, 10'h010, 1, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));
    tbl.push_back(mk(1, 10'h15A, 0, 1,1,8'h10,8'h5A, 0,8'hA5, 0,0));
    tbl.push_back(mk(0, 10'h000, 0, 0,0,8'h00,8'h00, 0,8'hA5, 0,0));

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) m_mem[i][a] = 8'h00;
    model_reset();
    ram_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset dut0", act[0], '0);
    chk("reset dut1", act[1], '0);
    ram_clr = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rv, tbl[k].d, tbl[k].ss);
      chk($sformatf("vec%0d", k), act[0], tbl[k].exp);
    end

    // rx_valid held high for 20 cycles must give exactly one write.
    nw0 = 0; nw1 = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 10'h155, 1'b0);
      if (en[0]) nw0++;
      if (en[1]) nw1++;
    end
    step(1'b0, 10'h155, 1'b0);
    chk_v("held rx_valid dut0 strobes", nw0, 1);
    chk_v("held rx_valid dut1 strobes", nw1, 1);

    // Auto-increment wraps FF -> 00.
    step(1'b1, 10'h0FF, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    step(1'b1, 10'h111, 1'b0);
    chk_v("autoinc write at FF", {14'h0, en[1], we[1], addr[1], wd[1]}, {14'h0, 2'b11, 8'hFF, 8'h11});
    step(1'b0, 10'h000, 1'b0);
    step(1'b1, 10'h122, 1'b0);
    chk_v("autoinc write at 00", {14'h0, en[1], we[1], addr[1], wd[1]}, {14'h0, 2'b11, 8'h00, 8'h22});
    step(1'b0, 10'h000, 1'b0);

    // Reset while both instances sit in READ_WAIT aborts the read.
    step(1'b1, 10'h200, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    step(1'b1, 10'h300, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    chk_v("busy before reset", {30'h0, bsy[1], bsy[0]}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("async reset dut0", act[0], '0);
    chk("async reset dut1", act[1], '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 10'h000, 1'b0);
    chk_v("no tx_valid after reset", {30'h0, txv[1], txv[0]}, 32'h0);

    // Randomized traffic over a small address window so reads hit written data.
    for (int k = 0; k < 600; k++) begin
      logic [1:0] op;
      logic [7:0] pl;
      op = 2'($urandom_range(0, 3));
      pl = (op == 2'b01) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), {op, pl}, ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
